baud_tick_gen: RTL and testbench
================================

// Module: baud_tick_gen
// PURPOSE
//  Parametrised UART baud/oversample tick generator; replaces chained modulo clock dividers.
//  Emits single-cycle enable strobes in the clk domain, never derived clocks.
//  Runtime-programmable integer+fractional divisor; phase resync on RX start-bit edge.
//  Feeds the UART RX sampler (tick_os/tick_mid) and the TX shifter (tick_bit).
// PARAMETERS
//  DIV_W       16  width of integer divisor (cycles per oversample tick)
//  FRAC_W      4   width of fractional divisor (units of 1/2^FRAC_W cycle)
//  OVERSAMPLE  16  oversample ticks per bit; even, >=4
//  DEFAULT_DIV 54  integer divisor after reset (100 MHz, 115200 baud, 16x)
// PORTS
//  clk       in   1       system clock
//  rst       in   1       asynchronous reset, active-low
//  en        in   1       generator enable; low = counters cleared, no ticks
//  div_int   in   DIV_W   integer divisor, legal >=2
//  div_frac  in   FRAC_W  fractional divisor
//  div_load  in   1       1-cycle pulse: capture div_int/div_frac into shadow register
//  resync    in   1       1-cycle pulse: restart bit phase (RX start edge)
//  tick_os   out  1       oversample strobe
//  tick_mid  out  1       mid-bit strobe (bit-centre sampling point)
//  tick_bit  out  1       end-of-bit strobe
//  cfg_err   out  1       1-cycle pulse: illegal divisor rejected
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0; counters/accumulator 0; active divisor = DEFAULT_DIV, frac 0.
//  Period: at each boundary {c,acc} <= acc + frac (FRAC_W+1-bit add); next period = int + c cycles.
//   Boundaries: a tick_os cycle, a resync cycle, or the first en=1 cycle after en=0.
//   Example: int=54, frac=4 -> periods 54,54,54,55 repeating.
//  tick_os: high for 1 cycle when the cycle counter completes the period; boundary at N -> tick at N+period.
//  os_cnt 0..OVERSAMPLE-1 increments on tick_os, wraps to 0.
//   tick_mid = tick_os & (os_cnt==OVERSAMPLE/2-1); tick_bit = tick_os & (os_cnt==OVERSAMPLE-1).
//  div_load: div_int<2 -> cfg_err next cycle, shadow unchanged; otherwise capture to shadow.
//   Shadow copied to active divisor at the next boundary; a period in progress completes at old length.
//  resync: cycle counter, os_cnt, acc cleared; no tick of any kind in the resync cycle, even if due.
//   Cycle N resync -> tick_os at N+D, tick_mid at N+(OVERSAMPLE/2)*D, D = current period length.
//  div_load and resync in same cycle: new value is applied at that resync boundary.
//  en=0: all counters held at 0, outputs 0; shadow/active divisor retained; div_load still accepted.
//  Reset mid-period: immediate; pending shadow value discarded.
//  All outputs registered; no combinational path from inputs to outputs.
// CONFIGURATION
//  BAUD_FRAC_EN defined: fractional accumulator present, behaviour as above.
//  BAUD_FRAC_EN undefined: div_frac ignored, accumulator absent; period always = active int.
// TESTING
//  1. rst release, en=1, no load -> tick_os every 54 cycles; tick_bit every 864; tick_mid 432 after each bit start.
//  2. load int=54, frac=4 (FRAC_EN) -> periods 54,54,54,55; 16 tick_os span 868 cycles.
//  3. resync 20 cycles into a period -> no tick that cycle; tick_os +54; tick_mid +432; tick_bit +864.
//  4. load int=1 -> cfg_err 1 cycle, period stays 54; load 27 mid-period -> current 54 completes, then 27s.
//  5. rst low mid-period -> outputs 0 with no clock edge; after release active divisor = 54.
//  6. macro undefined, int=54, frac=4 -> steady 54-cycle periods; en low 100 cycles -> no ticks, restart clean.

Source files
------------

// File: rtl/baud_tick_gen.sv
// UART baud/oversample tick generator: 1-cycle enable strobes, int+frac divisor.
// Fractional accumulator built only when BAUD_FRAC_EN is defined.
module baud_tick_gen #(
  parameter int DIV_W       = 16,
  parameter int FRAC_W      = 4,
  parameter int OVERSAMPLE  = 16,
  parameter int DEFAULT_DIV = 54
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic             div_load,
  input  logic             resync,
  output logic             tick_os,
  output logic             tick_mid,
  output logic             tick_bit,
  output logic             cfg_err
);

  localparam int PW   = DIV_W + 1;
  localparam int OS_W = $clog2(OVERSAMPLE);

  logic             r_en_d;
  logic [PW-1:0]    r_cnt;
  logic [PW-1:0]    r_per;
  logic [OS_W-1:0]  r_os;
  logic [DIV_W-1:0] r_sh_int;
  logic             r_tick_os;
  logic             r_tick_mid;
  logic             r_tick_bit;
  logic             r_cfg_err;

  logic             w_bad;
  logic             w_load_ok;
  logic [DIV_W-1:0] w_int;
  logic             w_tick;
  logic             w_bnd;
  logic [PW-1:0]    w_per;
  logic [OS_W-1:0]  w_os_inc;

  assign w_bad     = div_int < DIV_W'(2);
  assign w_load_ok = div_load & ~w_bad;
  // a load in a boundary cycle takes effect at that same boundary
  assign w_int     = w_load_ok ? div_int : r_sh_int;

  assign w_tick = en & r_en_d & ~resync &
                  (r_cnt == r_per - PW'(1));
  assign w_bnd  = en & (resync | ~r_en_d | w_tick);

  assign w_os_inc = (r_os == OS_W'(OVERSAMPLE-1)) ?
                    '0 : r_os + OS_W'(1);

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] r_sh_frac;
  logic [FRAC_W-1:0] r_acc;
  logic [FRAC_W-1:0] w_frac;
  logic [FRAC_W-1:0] w_acc_base;
  logic [FRAC_W-1:0] w_acc_nx;
  logic              w_c;

  assign w_frac     = w_load_ok ? div_frac : r_sh_frac;
  assign w_acc_base = resync ? '0 : r_acc;
  assign {w_c, w_acc_nx} = {1'b0, w_acc_base} +
                           {1'b0, w_frac};
  assign w_per = {1'b0, w_int} + PW'(w_c);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh_frac <= '0;
      r_acc     <= '0;
    end else begin
      if (w_load_ok)
        r_sh_frac <= div_frac;
      if (!en)
        r_acc <= '0;
      else if (w_bnd)
        r_acc <= w_acc_nx;
    end
  end
`else
  logic w_unused_frac;
  assign w_unused_frac = ^div_frac;
  assign w_per = {1'b0, w_int};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en_d     <= 1'b0;
      r_cnt      <= '0;
      r_per      <= PW'(DEFAULT_DIV);
      r_os       <= '0;
      r_sh_int   <= DIV_W'(DEFAULT_DIV);
      r_tick_os  <= 1'b0;
      r_tick_mid <= 1'b0;
      r_tick_bit <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_en_d     <= en;
      r_cfg_err  <= div_load & w_bad;
      r_tick_os  <= w_tick;
      r_tick_mid <= w_tick &
                    (r_os == OS_W'(OVERSAMPLE/2-1));
      r_tick_bit <= w_tick &
                    (r_os == OS_W'(OVERSAMPLE-1));
      if (w_load_ok)
        r_sh_int <= div_int;
      if (!en) begin
        r_cnt <= '0;
        r_os  <= '0;
      end else if (w_bnd) begin
        r_cnt <= '0;
        r_per <= w_per;
        if (resync)
          r_os <= '0;
        else if (w_tick)
          r_os <= w_os_inc;
      end else begin
        r_cnt <= r_cnt + PW'(1);
      end
    end
  end

  assign tick_os  = r_tick_os;
  assign tick_mid = r_tick_mid;
  assign tick_bit = r_tick_bit;
  assign cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Scoreboard bench for baud_tick_gen: expected strobe cycles
// are queued when stimulus is applied and popped as strobes appear.
module tb_baud_tick_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [15:0] div_int = 16'd54;
  logic [3:0]  div_frac = 4'd0;
  logic        div_load = 1'b0;
  logic        resync = 1'b0;
  logic        tick_os;
  logic        tick_mid;
  logic        tick_bit;
  logic        cfg_err;

  baud_tick_gen dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_int  (div_int),
    .div_frac (div_frac),
    .div_load (div_load),
    .resync   (resync),
    .tick_os  (tick_os),
    .tick_mid (tick_mid),
    .tick_bit (tick_bit),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  int q_os[$];
  int q_mid[$];
  int q_bit[$];
  int q_err[$];

  task automatic mon(input string tag, input logic v,
                     ref int q[$]);
    if (v) begin
      if (q.size() == 0)
        chk({tag, "_extra"}, cyc, -1);
      else
        chk({tag, "_time"}, cyc, q.pop_front());
    end else if (q.size() > 0 && q[0] <= cyc) begin
      chk({tag, "_miss"}, -1, q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    mon("tick_os", tick_os, q_os);
    mon("tick_mid", tick_mid, q_mid);
    mon("tick_bit", tick_bit, q_bit);
    mon("cfg_err", cfg_err, q_err);
  end

  // reference state: next boundary, accumulator before it, os count
  int m_b;
  int m_acc;
  int m_os;

  // upto_bnd=1: stop at first boundary >= lim (load applies there)
  // upto_bnd=0: only ticks strictly before lim (resync/en-off edge)
  task automatic plan(input int i, input int f,
                      input int lim, input bit upto_bnd);
    int c;
    int na;
    int t;
    while (1) begin
      c  = 0;
      na = m_acc;
`ifdef BAUD_FRAC_EN
      c  = (m_acc + f) / 16;
      na = (m_acc + f) % 16;
`else
      if (f < 0) na = 0;
`endif
      t = m_b + i + c;
      if (upto_bnd ? (m_b >= lim) : (t >= lim)) break;
      q_os.push_back(t);
      if (m_os == 7)  q_mid.push_back(t);
      if (m_os == 15) q_bit.push_back(t);
      m_os  = (m_os + 1) % 16;
      m_acc = na;
      m_b   = t;
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic load_at(input int e, input int i,
                         input int f);
    wait_cyc(e - 1);
    div_int  = 16'(i);
    div_frac = 4'(f);
    div_load = 1'b1;
    wait_cyc(e);
    div_load = 1'b0;
  endtask

  task automatic restart(input int e);
    m_b   = e;
    m_acc = 0;
    m_os  = 0;
  endtask

  int s, r, l1, l2, l3, e0, e2, t;

  initial begin
    #3;
    chk("rst_tick_os", int'(tick_os), 0);
    chk("rst_tick_mid", int'(tick_mid), 0);
    chk("rst_tick_bit", int'(tick_bit), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    wait_cyc(3);
    rst = 1'b1;

    // start-up with the default divisor
    wait_cyc(5);
    en = 1'b1;
    s = 6;
    restart(s);
    r = s + 54*17 + 20;
    plan(54, 0, r, 1'b0);

    // resync 20 cycles into a period
    wait_cyc(r - 1);
    resync = 1'b1;
    wait_cyc(r);
    resync = 1'b0;
    restart(r);

    // illegal load, then legal 27 mid-period
    l1 = r + 54*17 + 10;
    l2 = l1 + 20;
    q_err.push_back(l1);
    plan(54, 0, l2, 1'b1);
    load_at(l1, 1, 0);
    load_at(l2, 27, 0);
    l3 = l2 + 24 + 27*20 + 13;
    plan(27, 0, l3, 1'b1);

    // integer + fractional divisor
    load_at(l3, 54, 4);
    e0 = l3 + 1000;
    plan(54, 4, e0, 1'b0);

    // enable low for 100 cycles
    wait_cyc(e0 - 1);
    en = 1'b0;
    e2 = e0 + 100;
    wait_cyc(e2 - 1);
    en = 1'b1;
    restart(e2);
    plan(54, 4, e2 + 1000, 1'b0);

    // async reset while tick_os is high
    t = m_b;
    void'(q_os.pop_back());
    if (q_mid.size() > 0 && q_mid[$] == t)
      void'(q_mid.pop_back());
    if (q_bit.size() > 0 && q_bit[$] == t)
      void'(q_bit.pop_back());
    load_at(t - 10, 27, 0);
    wait_cyc(t);
    chk("pre_rst_tick_os", int'(tick_os), 1);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_tick_os", int'(tick_os), 0);
    chk("async_rst_tick_mid", int'(tick_mid), 0);
    chk("async_rst_tick_bit", int'(tick_bit), 0);
    wait_cyc(t + 3);
    rst = 1'b1;
    restart(t + 4);
    plan(54, 0, t + 4 + 54*17 + 5, 1'b0);
    wait_cyc(t + 4 + 54*17 + 10);

    chk("os_left", q_os.size(), 0);
    chk("mid_left", q_mid.size(), 0);
    chk("bit_left", q_bit.size(), 0);
    chk("err_left", q_err.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
